btn_conditioner: RTL and testbench

Conditions the two raw push-buttons that drive the three-state sequencing FSM, producing its `pause` and `restart` control inputs. It sits directly upstream of the FSM: it synchronises each asynchronous button, debounces it, and converts it to the form the FSM consumes. `restart` is a single-cycle pulse. `pause` is a latched level. All outputs are registered and glitch-free.

---
 rtl/btn_pkg.sv | 7 +
 rtl/btn_debounce.sv | 56 +++++
 rtl/btn_conditioner.sv | 80 ++++++++
 tb/tb_btn_conditioner.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared constants for the push-button conditioning path.
package btn_pkg;

  localparam int BTN_DEBOUNCE_DEFAULT = 16;
  localparam int BTN_SYNC_STAGES      = 2;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchroniser, debounce counter, accepted level.
// rise/fall are combinational strobes on the edge where the level changes.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [BTN_SYNC_STAGES-1:0] sync_q, sync_d;
  logic                       stable_q, stable_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       in_s;
  logic                       accept;

  assign in_s   = sync_q[BTN_SYNC_STAGES-1];
  assign accept = (in_s != stable_q) && (cnt_q == CNT_MAX);

  always_comb begin
    sync_d   = {sync_q[BTN_SYNC_STAGES-2:0], raw};
    stable_d = stable_q;
    cnt_d    = cnt_q + CNT_W'(1);
    if (in_s == stable_q) begin
      cnt_d = '0;
    end else if (accept) begin
      stable_d = in_s;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level = stable_q;
  assign rise  = accept & in_s;
  assign fall  = accept & ~in_s;

endmodule

// File: rtl/btn_conditioner.sv
// Pause/restart button conditioner feeding the sequencing FSM.
// BTN_PAUSE_TOGGLE_EN selects toggle-latch pause; otherwise hold-to-pause.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_pause_raw,
  input  logic btn_restart_raw,
  output logic pause,
  output logic restart,
  output logic pause_clean
);

  logic p_level, p_rise, p_fall;
  logic r_level, r_rise, r_fall;
  logic pause_q, pause_d;
  logic restart_q, restart_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_pause (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btn_pause_raw),
    .level(p_level),
    .rise (p_rise),
    .fall (p_fall)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_restart (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btn_restart_raw),
    .level(r_level),
    .rise (r_rise),
    .fall (r_fall)
  );

  always_comb begin
    restart_d = r_rise;
    pause_d   = pause_q;
`ifdef BTN_PAUSE_TOGGLE_EN
    // restart wins over a same-edge pause toggle
    if (r_rise) begin
      pause_d = 1'b0;
    end else if (p_rise) begin
      pause_d = ~pause_q;
    end
`else
    if (p_rise) begin
      pause_d = 1'b1;
    end else if (p_fall) begin
      pause_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause_q   <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      pause_q   <= pause_d;
      restart_q <= restart_d;
    end
  end

  assign pause       = pause_q;
  assign restart     = restart_q;
  assign pause_clean = p_level;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES = 4.
// Expectations follow BTN_PAUSE_TOGGLE_EN when it is defined.
module tb_btn_conditioner;

`ifdef BTN_PAUSE_TOGGLE_EN
  localparam bit TOG = 1'b1;
`else
  localparam bit TOG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_pause_raw = 1'b0;
  logic btn_restart_raw = 1'b0;
  logic pause, restart, pause_clean;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .btn_pause_raw  (btn_pause_raw),
    .btn_restart_raw(btn_restart_raw),
    .pause          (pause),
    .restart        (restart),
    .pause_clean    (pause_clean)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %b want %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_c, exp_p;

    // reset held from time 0
    repeat (3) step();
    check("rst_pause", pause, 1'b0);
    check("rst_restart", restart, 1'b0);
    check("rst_clean", pause_clean, 1'b0);
    #2 rst_n = 1'b1;
    step();

    // single restart press held 20 cycles
    btn_restart_raw = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      check($sformatf("restart_e%0d", i), restart, (i == 6));
    end
    check("restart_no_pause", pause, 1'b0);
    btn_restart_raw = 1'b0;
    repeat (10) step();

    // glitches of 1, 2, 3 cycles
    for (int len = 1; len <= 3; len++) begin
      btn_pause_raw = 1'b1;
      for (int k = 0; k < len; k++) begin
        step();
        check($sformatf("glitch%0d_clean", len), pause_clean, 1'b0);
        check($sformatf("glitch%0d_pause", len), pause, 1'b0);
      end
      btn_pause_raw = 1'b0;
      for (int k = 0; k < 10; k++) begin
        step();
        check($sformatf("glitch%0d_clean", len), pause_clean, 1'b0);
        check($sformatf("glitch%0d_pause", len), pause, 1'b0);
      end
    end

    // two 8-cycle pause presses, 16 cycles apart
    for (int i = 1; i <= 32; i++) begin
      btn_pause_raw = ((i >= 1) && (i <= 8)) || ((i >= 17) && (i <= 24));
      step();
      exp_c = ((i >= 6) && (i <= 13)) || ((i >= 22) && (i <= 29));
      exp_p = TOG ? ((i >= 6) && (i <= 21)) : exp_c;
      check($sformatf("tog_clean_e%0d", i), pause_clean, exp_c);
      check($sformatf("tog_pause_e%0d", i), pause, exp_p);
    end

    // set pause, then press both together
    btn_pause_raw = 1'b1;
    repeat (8) step();
    btn_pause_raw = 1'b0;
    repeat (8) step();
    check("pre_sim_pause", pause, TOG);
    check("pre_sim_clean", pause_clean, 1'b0);
    btn_pause_raw   = 1'b1;
    btn_restart_raw = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      exp_p = TOG ? (i < 6) : (i >= 6);
      check($sformatf("sim_restart_e%0d", i), restart, (i == 6));
      check($sformatf("sim_pause_e%0d", i), pause, exp_p);
    end
    btn_pause_raw   = 1'b0;
    btn_restart_raw = 1'b0;
    repeat (12) step();
    check("post_sim_pause", pause, 1'b0);
    check("post_sim_clean", pause_clean, 1'b0);
    check("post_sim_restart", restart, 1'b0);

    // reset at cycle 3 of a press, button still held
    btn_pause_raw = 1'b1;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_clean", pause_clean, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("rel_clean_e%0d", i), pause_clean, (i >= 6));
      check($sformatf("rel_pause_e%0d", i), pause, (i >= 6));
    end

    // asynchronous reset with outputs high, no clock edge
    #2 rst_n = 1'b0;
    #1;
    check("async_pause", pause, 1'b0);
    check("async_clean", pause_clean, 1'b0);
    check("async_restart", restart, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
